// File: rtl/speedmean.sv
// speedmean: moving-average filter for the X/Y wind-velocity components.
// Keeps the last 2^MAXLOG {X,Y} samples in a circular buffer and produces
// the mean over the last 2^lg samples, lg = min(spdmeanlen, MAXLOG).
//
// Ports:
//   clock      in   master clock (2 MHz)
//   reset      in   asynchronous active-high reset
//   spdmeanlen in   log2 of averaging length, saturates at MAXLOG
//   inen       in   one-clock strobe, valid input sample
//   speedXin   in   signed X speed, 10 fractional bits
//   speedYin   in   signed Y speed, 10 fractional bits
//   speedX     out  averaged X speed (registered)
//   speedY     out  averaged Y speed (registered)
//   speeden    out  one-clock pulse when speedX/speedY update
//   overrun    out  sticky, set when an inen arrives while busy
//
// Build option: define SPEEDMEAN_ROUND_EN to round the mean half up;
// otherwise the mean is floored (arithmetic shift).
`timescale 1ns/1ps
module speedmean #(
  parameter int MAXLOG = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         spdmeanlen,
  input  logic               inen,
  input  logic signed [15:0] speedXin,
  input  logic signed [15:0] speedYin,
  output logic signed [15:0] speedX,
  output logic signed [15:0] speedY,
  output logic               speeden,
  output logic               overrun
);

  localparam int DEPTH = 1 << MAXLOG;
  localparam int SUMW  = 16 + MAXLOG;
  localparam int LGW   = $clog2(MAXLOG + 1);

  localparam logic [3:0]        MAXLOG_LEN = 4'(MAXLOG);
  localparam logic [LGW-1:0]    MAXLOG_LG  = LGW'(MAXLOG);
  localparam logic [LGW-1:0]    LG_ONE     = {{(LGW-1){1'b0}}, 1'b1};
  localparam logic [MAXLOG:0]   LEN_ONE    = {{MAXLOG{1'b0}}, 1'b1};
  localparam logic [MAXLOG-1:0] WPTR_ONE   = {{(MAXLOG-1){1'b0}}, 1'b1};
  localparam logic signed [SUMW-1:0] SUM_ZERO = {SUMW{1'b0}};
  localparam logic signed [SUMW-1:0] SUM_ONE  = {{(SUMW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    UPD  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [LGW-1:0]          lg_r;
  logic [MAXLOG:0]         fill_r;
  logic [MAXLOG-1:0]       wptr_r;
  logic [MAXLOG-1:0]       rd_addr_r;
  logic signed [15:0]      new_x_r;
  logic signed [15:0]      new_y_r;
  logic signed [SUMW-1:0]  sum_x_r;
  logic signed [SUMW-1:0]  sum_y_r;
  logic [31:0]             mem_r [DEPTH];
  logic [31:0]             rdata_r;

  logic [LGW-1:0]          lg_sat_s;
  logic [MAXLOG:0]         len_sat_s;
  logic [MAXLOG:0]         len_s;
  logic                    full_s;
  logic signed [SUMW-1:0]  old_x_s;
  logic signed [SUMW-1:0]  old_y_s;
  logic signed [SUMW-1:0]  upd_x_s;
  logic signed [SUMW-1:0]  upd_y_s;
  logic signed [SUMW-1:0]  rnd_s;
  logic signed [SUMW-1:0]  res_x_s;
  logic signed [SUMW-1:0]  res_y_s;

  // Sign-extend a 16-bit sample to the running-sum width.
  function automatic logic signed [SUMW-1:0] sext16(input logic [15:0] v);
    return {{MAXLOG{v[15]}}, v};
  endfunction

  // Length saturation, window-full test, sum update and output scaling.
  always_comb begin
    lg_sat_s  = (spdmeanlen > MAXLOG_LEN) ? MAXLOG_LG : spdmeanlen[LGW-1:0];
    len_sat_s = LEN_ONE << lg_sat_s;
    len_s     = LEN_ONE << lg_r;
    full_s    = (fill_r == len_s);
    // While filling, the slot L back holds stale data and must not be removed.
    old_x_s   = full_s ? sext16(rdata_r[31:16]) : SUM_ZERO;
    old_y_s   = full_s ? sext16(rdata_r[15:0])  : SUM_ZERO;
    upd_x_s   = sum_x_r + sext16(new_x_r) - old_x_s;
    upd_y_s   = sum_y_r + sext16(new_y_r) - old_y_s;
`ifdef SPEEDMEAN_ROUND_EN
    rnd_s     = (lg_r == {LGW{1'b0}}) ? SUM_ZERO : (SUM_ONE << (lg_r - LG_ONE));
`else
    rnd_s     = SUM_ZERO;
`endif
    res_x_s   = (sum_x_r + rnd_s) >>> lg_r;
    res_y_s   = (sum_y_r + rnd_s) >>> lg_r;
  end

  // Sample buffer: synchronous read in RD, write of the new sample in UPD.
  always_ff @(posedge clock) begin
    if (state_r == UPD) begin
      mem_r[wptr_r] <= {new_x_r, new_y_r};
    end
    if (state_r == RD) begin
      rdata_r <= mem_r[rd_addr_r];
    end
  end

  // Control FSM, running sums, fill/pointer bookkeeping and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      lg_r      <= {LGW{1'b0}};
      fill_r    <= {(MAXLOG+1){1'b0}};
      wptr_r    <= {MAXLOG{1'b0}};
      rd_addr_r <= {MAXLOG{1'b0}};
      new_x_r   <= 16'sd0;
      new_y_r   <= 16'sd0;
      sum_x_r   <= SUM_ZERO;
      sum_y_r   <= SUM_ZERO;
      speedX    <= 16'sd0;
      speedY    <= 16'sd0;
      speeden   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      speeden <= 1'b0;
      if (inen && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          // Length change flushes the window; wptr and buffer are kept.
          if (lg_sat_s != lg_r) begin
            lg_r    <= lg_sat_s;
            sum_x_r <= SUM_ZERO;
            sum_y_r <= SUM_ZERO;
            fill_r  <= {(MAXLOG+1){1'b0}};
          end
          // Use the new length directly so a coincident sample sees it.
          if (inen) begin
            new_x_r   <= speedXin;
            new_y_r   <= speedYin;
            rd_addr_r <= wptr_r - len_sat_s[MAXLOG-1:0];
            state_r   <= RD;
          end
        end
        RD: begin
          state_r <= UPD;
        end
        UPD: begin
          sum_x_r <= upd_x_s;
          sum_y_r <= upd_y_s;
          wptr_r  <= wptr_r + WPTR_ONE;
          if (!full_s) begin
            fill_r <= fill_r + LEN_ONE;
          end
          state_r <= OUT;
        end
        OUT: begin
          if (full_s) begin
            speedX  <= res_x_s[15:0];
            speedY  <= res_y_s[15:0];
            speeden <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speedmean.sv
`timescale 1ns/1ps
module tb_speedmean;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [3:0]         spdmeanlen = 4'd0;
  logic               inen = 1'b0;
  logic signed [15:0] speedXin = 16'sd0;
  logic signed [15:0] speedYin = 16'sd0;
  logic signed [15:0] speedX;
  logic signed [15:0] speedY;
  logic               speeden;
  logic               overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: samples since the last flush, current lg, last output.
  int hist_x[$];
  int hist_y[$];
  int m_lg   = 0;
  int last_x = 0;
  int last_y = 0;

  always #5 clock = ~clock;

  speedmean #(.MAXLOG(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .spdmeanlen(spdmeanlen),
    .inen      (inen),
    .speedXin  (speedXin),
    .speedYin  (speedYin),
    .speedX    (speedX),
    .speedY    (speedY),
    .speeden   (speeden),
    .overrun   (overrun)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat_lg(input int v);
    return (v > 6) ? 6 : v;
  endfunction

  // Mean of the last 2^lgv samples: floor division, or round-half-up if enabled.
  function automatic int model_mean(input int hist[$], input int lgv);
    longint s;
    longint d;
    longint q;
    s = 0;
    d = longint'(1) << lgv;
    for (int i = hist.size() - (1 << lgv); i < hist.size(); i++) s += hist[i];
`ifdef SPEEDMEAN_ROUND_EN
    if (lgv > 0) s += d / 2;
`endif
    q = s / d;
    if (((s % d) != 0) && (s < 0)) q -= 1;
    return int'(q);
  endfunction

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  task automatic model_push(input int x, input int y);
    hist_x.push_back(x);
    hist_y.push_back(y);
    if (hist_x.size() > 64) begin
      void'(hist_x.pop_front());
      void'(hist_y.pop_front());
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after n+3.
  task automatic send(input int x, input int y);
    int l_sat;
    l_sat = sat_lg(int'(spdmeanlen));
    if (l_sat != m_lg) begin
      m_lg = l_sat;
      hist_x.delete();
      hist_y.delete();
    end
    speedXin = 16'(x);
    speedYin = 16'(y);
    inen = 1'b1;
    model_push(x, y);
    @(negedge clock);
    inen = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_val("early_en", int'(speeden), 0);
    @(negedge clock);
    if (hist_x.size() >= (1 << m_lg)) begin
      last_x = model_mean(hist_x, m_lg);
      last_y = model_mean(hist_y, m_lg);
      check_val("en", int'(speeden), 1);
    end else begin
      check_val("fill_en", int'(speeden), 0);
    end
    check_val("x", int'(speedX), last_x);
    check_val("y", int'(speedY), last_y);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_val("pulse_low", int'(speeden), 0);
    end
  endtask

  int exp_round;
  int seen_en;

  initial begin
`ifdef SPEEDMEAN_ROUND_EN
    exp_round = -2;
`else
    exp_round = -3;
`endif
    // Reset state
    repeat (3) @(negedge clock);
    check_val("rst_x", int'(speedX), 0);
    check_val("rst_y", int'(speedY), 0);
    check_val("rst_en", int'(speeden), 0);
    check_val("rst_ovr", int'(overrun), 0);
    reset = 1'b0;
    @(negedge clock);

    // L = 1
    spdmeanlen = 4'd0;
    send(100, -100);
    check_val("l1_x", int'(speedX), 100);
    check_val("l1_y", int'(speedY), -100);
    idle(2);

    // L = 4
    spdmeanlen = 4'd2;
    idle(1);
    send(4, -4);  idle(1);
    send(8, -8);  idle(1);
    send(12, -12); idle(1);
    send(16, -16);
    check_val("l4_x", int'(speedX), 10);
    send(20, -20);
    check_val("l4_x5", int'(speedX), 14);
    idle(1);

    // Rounding on negative sum
    spdmeanlen = 4'd1;
    send(-3, 7);
    send(-2, 8);
    check_val("round_x", int'(speedX), exp_round);
    idle(1);

    // Length change mid-stream: 2 -> 1
    spdmeanlen = 4'd2;
    for (int i = 0; i < 5; i++) send(rnd16(), rnd16());
    spdmeanlen = 4'd1;
    send(10, 30);
    send(20, 50);
    check_val("flush_x", int'(speedX), 15);
    check_val("flush_y", int'(speedY), 40);
    idle(2);

    // Saturation: 9 behaves as 64
    spdmeanlen = 4'd9;
    for (int i = 0; i < 64; i++) send(rnd16(), rnd16());
    check_val("sat_en", int'(speeden), 1);
    idle(1);
    check_val("ovr_clear", int'(overrun), 0);

    // Overrun: second inen 2 cycles later is dropped
    spdmeanlen = 4'd0;
    idle(1);
    hist_x.delete(); hist_y.delete(); m_lg = 0;
    speedXin = 16'sd7; speedYin = 16'sd9; inen = 1'b1;
    @(negedge clock); inen = 1'b0;
    @(negedge clock); speedXin = 16'sd99; speedYin = 16'sd99; inen = 1'b1;
    @(negedge clock); inen = 1'b0;
    @(negedge clock);
    model_push(7, 9);
    last_x = 7; last_y = 9;
    check_val("ovr_en", int'(speeden), 1);
    check_val("ovr_x", int'(speedX), 7);
    idle(4);
    check_val("ovr_set", int'(overrun), 1);
    send(-55, 66);
    check_val("ovr_sticky", int'(overrun), 1);
    idle(1);

    // Reset asserted while in UPD
    speedXin = 16'sd500; speedYin = 16'sd500; inen = 1'b1;
    @(negedge clock); inen = 1'b0;
    @(negedge clock); reset = 1'b1;
    #1;
    check_val("arst_x", int'(speedX), 0);
    check_val("arst_y", int'(speedY), 0);
    check_val("arst_en", int'(speeden), 0);
    check_val("arst_ovr", int'(overrun), 0);
    @(negedge clock); reset = 1'b0;
    hist_x.delete(); hist_y.delete(); m_lg = 0; last_x = 0; last_y = 0;
    seen_en = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (speeden) seen_en++;
    end
    check_val("arst_no_en", seen_en, 0);
    send(5, 6);

    // Randomised stream with occasional length changes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) spdmeanlen = 4'($urandom_range(0, 9));
      idle($urandom_range(0, 3));
      send(rnd16(), rnd16());
    end
    idle(2);
    check_val("final_ovr", int'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
